// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// Holds the sequencer state enum and the default PC width.
package pc_sequencer_pkg;

    localparam int unsigned PcwDefault = 10;
    localparam int unsigned RetiredW   = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Saturating increment for the retired-instruction counter.
    function automatic logic [RetiredW-1:0] sat_inc(input logic [RetiredW-1:0] val);
        return (val == {RetiredW{1'b1}}) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/pc_sequencer_branch_resolve.sv
// Combinational branch resolution and next-PC selection for a retiring instruction.
// Stall and halt are applied by the caller; this block only picks branch vs. sequential.
module branch_resolve #(
    parameter int unsigned PCW = 10
) (
    input  logic [PCW-1:0] pc_i,
    input  logic           abs_branch_i,
    input  logic           rel_branch_i,
    input  logic           branch_flag_i,
    input  logic           branch_invert_i,
    input  logic           zero_flag_i,
    input  logic           neg_flag_i,
    input  logic [PCW-1:0] abs_target_i,
    input  logic [7:0]     rel_offset_i,
    output logic           taken_o,
    output logic [PCW-1:0] next_pc_o
);

    logic           flag_sel;
    logic [PCW-1:0] rel_ext;

    assign flag_sel = branch_flag_i ? neg_flag_i : zero_flag_i;
    assign taken_o  = (abs_branch_i | rel_branch_i) & (flag_sel ^ branch_invert_i);

    // Sign-extend the 8-bit displacement to PC width; the add wraps modulo 2^PCW.
    assign rel_ext = PCW'($signed(rel_offset_i));

    always_comb begin
        next_pc_o = pc_i + 1'b1;
        if (taken_o) begin
            if (abs_branch_i) begin
                next_pc_o = abs_target_i;
            end else begin
                next_pc_o = pc_i + rel_ext;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE control with branch, stall and halt handling.
// Tracks the fetch address and a saturating count of retired instructions per run.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned PCW        = PcwDefault,
    parameter int unsigned START_ADDR = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stall,
    input  logic                halt,
    input  logic                abs_branch,
    input  logic                rel_branch,
    input  logic                branch_flag,
    input  logic                branch_invert,
    input  logic                zero_flag,
    input  logic                neg_flag,
    input  logic [PCW-1:0]      abs_target,
    input  logic [7:0]          rel_offset,
    output logic [PCW-1:0]      pc,
    output logic                fetch_en,
    output logic                branch_taken,
    output logic                done,
    output logic [RetiredW-1:0] retired
);

    localparam logic [PCW-1:0] StartPc = PCW'(START_ADDR);

    state_e                state_q, state_d;
    logic [PCW-1:0]        pc_q, pc_d;
    logic [RetiredW-1:0]   retired_q, retired_d;
    logic                  done_q, done_d;
    logic                  branch_taken_q, branch_taken_d;

    logic                  taken;
    logic [PCW-1:0]        resolved_pc;

    branch_resolve #(
        .PCW (PCW)
    ) u_branch_resolve (
        .pc_i            (pc_q),
        .abs_branch_i    (abs_branch),
        .rel_branch_i    (rel_branch),
        .branch_flag_i   (branch_flag),
        .branch_invert_i (branch_invert),
        .zero_flag_i     (zero_flag),
        .neg_flag_i      (neg_flag),
        .abs_target_i    (abs_target),
        .rel_offset_i    (rel_offset),
        .taken_o         (taken),
        .next_pc_o       (resolved_pc)
    );

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        retired_d      = retired_q;
        branch_taken_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRun;
                    pc_d      = StartPc;
                    retired_d = '0;
                end
            end
            StRun: begin
                if (!stall) begin
                    retired_d = sat_inc(retired_q);
                    if (halt) begin
                        state_d = StDone;
                    end else begin
                        pc_d           = resolved_pc;
                        branch_taken_d = taken;
                    end
                end
            end
            StDone: begin
                if (start) begin
                    state_d   = StRun;
                    pc_d      = StartPc;
                    retired_d = '0;
                end
            end
            default: begin
                state_d   = StIdle;
                pc_d      = StartPc;
                retired_d = '0;
            end
        endcase

        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= StIdle;
            pc_q           <= StartPc;
            retired_q      <= '0;
            done_q         <= 1'b0;
            branch_taken_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            retired_q      <= retired_d;
            done_q         <= done_d;
            branch_taken_q <= branch_taken_d;
        end
    end

    assign pc           = pc_q;
    assign fetch_en     = (state_q == StRun);
    assign branch_taken = branch_taken_q;
    assign done         = done_q;
    assign retired      = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a driver pushes model expectations, a monitor pops and checks.
module tb_pc_sequencer;

    localparam int PCW  = 10;
    localparam int MODN = 1 << PCW;

    logic            clk;
    logic            reset;
    logic            start;
    logic            stall;
    logic            halt;
    logic            abs_branch;
    logic            rel_branch;
    logic            branch_flag;
    logic            branch_invert;
    logic            zero_flag;
    logic            neg_flag;
    logic [PCW-1:0]  abs_target;
    logic [7:0]      rel_offset;
    logic [PCW-1:0]  pc;
    logic            fetch_en;
    logic            branch_taken;
    logic            done;
    logic [15:0]     retired;

    pc_sequencer #(
        .PCW        (PCW),
        .START_ADDR (0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stall         (stall),
        .halt          (halt),
        .abs_branch    (abs_branch),
        .rel_branch    (rel_branch),
        .branch_flag   (branch_flag),
        .branch_invert (branch_invert),
        .zero_flag     (zero_flag),
        .neg_flag      (neg_flag),
        .abs_target    (abs_target),
        .rel_offset    (rel_offset),
        .pc            (pc),
        .fetch_en      (fetch_en),
        .branch_taken  (branch_taken),
        .done          (done),
        .retired       (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    pc;
        bit    fetch_en;
        bit    branch_taken;
        bit    done;
        int    retired;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: "idle", "run", "done" as plain strings, pc and count as integers.
    string m_mode = "idle";
    int    m_pc   = 0;
    int    m_ret  = 0;
    bit    m_bt   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    // Monitor: every edge where an expectation exists, compare sampled outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".pc"}, int'(pc), e.pc);
                check({e.name, ".fetch_en"}, int'(fetch_en), int'(e.fetch_en));
                check({e.name, ".branch_taken"}, int'(branch_taken), int'(e.branch_taken));
                check({e.name, ".done"}, int'(done), int'(e.done));
                check({e.name, ".retired"}, int'(retired), e.retired);
            end
        end
    end

    task automatic clear_inputs();
        reset = 1'b1; start = 1'b0; stall = 1'b0; halt = 1'b0;
        abs_branch = 1'b0; rel_branch = 1'b0; branch_flag = 1'b0; branch_invert = 1'b0;
        zero_flag = 1'b0; neg_flag = 1'b0; abs_target = '0; rel_offset = '0;
    endtask

    // Apply the current inputs to the model, push the expectation, advance one cycle.
    task automatic step(input string name);
        exp_t e;
        bit   take;
        bit   flag;
        int   off;
        m_bt = 0;
        if (!reset) begin
            m_mode = "idle"; m_pc = 0; m_ret = 0;
        end else if (m_mode == "idle" || m_mode == "done") begin
            if (start) begin
                m_mode = "run"; m_pc = 0; m_ret = 0;
            end
        end else if (!stall) begin
            m_ret = (m_ret < 65535) ? m_ret + 1 : 65535;
            if (halt) begin
                m_mode = "done";
            end else begin
                flag = branch_flag ? neg_flag : zero_flag;
                take = (abs_branch || rel_branch) && (flag != branch_invert);
                off  = int'($signed(rel_offset));
                if (take && abs_branch) m_pc = int'(abs_target);
                else if (take) m_pc = (m_pc + off + MODN) % MODN;
                else m_pc = (m_pc + 1) % MODN;
                m_bt = take;
            end
        end
        e.name         = name;
        e.pc           = m_pc;
        e.fetch_en     = (m_mode == "run");
        e.branch_taken = m_bt;
        e.done         = (m_mode == "done");
        e.retired      = m_ret;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        int n = 0;
        clear_inputs();
        while (m_pc != target && n < 2000) begin
            step("seq");
            n++;
        end
        check("run_to_reached", m_pc, target);
    endtask

    task automatic jump_abs(input int target);
        clear_inputs();
        abs_branch = 1'b1; zero_flag = 1'b1; abs_target = PCW'(target);
        step("abs_jump");
        clear_inputs();
    endtask

    initial begin
        int drain;
        clear_inputs();
        @(negedge clk);

        reset = 1'b0;
        step("reset0");
        step("reset1");
        clear_inputs();
        step("idle_hold");

        start = 1'b1;
        step("start");
        clear_inputs();
        for (int i = 0; i < 5; i++) step("seq5");

        run_to(8);
        rel_branch = 1'b1; zero_flag = 1'b1; rel_offset = 8'hFD;
        step("rel_taken");
        clear_inputs();
        step("after_rel");
        run_to(8);
        rel_branch = 1'b1; zero_flag = 1'b0; rel_offset = 8'hFD;
        step("rel_not_taken");

        run_to(12);
        abs_branch = 1'b1; rel_branch = 1'b1; branch_flag = 1'b1; neg_flag = 1'b1;
        abs_target = 10'd100; rel_offset = 8'h05;
        step("abs_over_rel");
        clear_inputs();

        jump_abs(1023);
        step("wrap");
        jump_abs(2);
        rel_branch = 1'b1; zero_flag = 1'b1; rel_offset = 8'hFB;
        step("rel_wrap");
        clear_inputs();
        rel_branch = 1'b1; branch_invert = 1'b1; zero_flag = 1'b0; rel_offset = 8'h7F;
        step("rel_inverted");
        clear_inputs();

        stall = 1'b1; halt = 1'b1; start = 1'b1;
        for (int i = 0; i < 3; i++) step("stall_halt");
        stall = 1'b0; start = 1'b0;
        step("halt");
        clear_inputs();
        step("done_hold");
        start = 1'b1;
        step("restart");
        clear_inputs();

        run_to(37);
        reset = 1'b0; start = 1'b1; abs_branch = 1'b1; zero_flag = 1'b1;
        step("reset_mid_run");
        clear_inputs();
        step("post_reset_idle");

        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(99) >= 2);
            start         = ($urandom_range(99) < 20);
            stall         = ($urandom_range(99) < 25);
            halt          = ($urandom_range(99) < 4);
            abs_branch    = ($urandom_range(99) < 15);
            rel_branch    = ($urandom_range(99) < 25);
            branch_flag   = 1'($urandom_range(1));
            branch_invert = 1'($urandom_range(1));
            zero_flag     = 1'($urandom_range(1));
            neg_flag      = 1'($urandom_range(1));
            abs_target    = PCW'($urandom_range(MODN - 1));
            rel_offset    = 8'($urandom_range(255));
            step("random");
        end
        clear_inputs();

        drain = 0;
        while (sb.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
